// File: rtl/tmnt_gpio_frontend_if.sv
// ---------------------------------------------------------------------------
// tmnt_gpio_frontend_if
//   Bundles the GPIO pad bank and the synthesiser-core side of the front end.
//   slave  : the front end (takes cs, pads and sigout; drives pads, core reset
//            and button outputs)
//   master : the chip wrapper / environment side
//
//   cs          chip select, 1 = selected, 0 = block and core held in reset
//   gpio_in     pad input values
//   gpio_out    pad output values
//   gpio_oe     pad output enables, 1 = drive
//   sigout      audio bit from the core
//   core_nrst   active-low core reset (async assert, sync release)
//   pb_level    debounced button levels
//   pb_press    one-cycle strobe on each 0->1 of pb_level
//   pb_release  one-cycle strobe on each 1->0 of pb_level
// ---------------------------------------------------------------------------
interface tmnt_gpio_frontend_if #(
  parameter int NUM_PB = 16,
  parameter int GPIO_W = 34
);
  logic              cs;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic              sigout;
  logic              core_nrst;
  logic [NUM_PB-1:0] pb_level;
  logic [NUM_PB-1:0] pb_press;
  logic [NUM_PB-1:0] pb_release;

  modport slave (
    input  cs, gpio_in, sigout,
    output gpio_out, gpio_oe, core_nrst, pb_level, pb_press, pb_release
  );

  modport master (
    output cs, gpio_in, sigout,
    input  gpio_out, gpio_oe, core_nrst, pb_level, pb_press, pb_release
  );
endinterface

// File: rtl/tmnt_gpio_frontend.sv
// ---------------------------------------------------------------------------
// tmnt_gpio_frontend
//   I/O front end between the breakout-board GPIO bank and the synth core.
//   - Combines nrst and cs into a synchronised core reset (async assert,
//     release on the 2nd clk edge after both are high).
//   - Synchronises and debounces NUM_PB pushbutton channels taken from
//     gpio_in[NUM_PB-1:0]; produces level, press and release per channel.
//   - Registers sigout onto gpio_out[SIGOUT_PIN]; the pin is driven only
//     while the core is out of reset. All other pads stay inputs.
//
//   Ports:
//     clk    system clock
//     nrst   board reset, asynchronous, active-low
//     bus    tmnt_gpio_frontend_if.slave (cs, pads, sigout, core_nrst,
//            pb_level / pb_press / pb_release)
//
//   Parameters:
//     NUM_PB        pushbutton channels, 1..GPIO_W-1
//     GPIO_W        GPIO bank width
//     SIGOUT_PIN    pad index for sigout, NUM_PB <= SIGOUT_PIN < GPIO_W
//     DEBOUNCE_CYC  consecutive differing cycles needed to accept a level, >= 1
//
//   Build option:
//     TMNT_DEBOUNCE_EN  defined   -> per-channel debounce counters
//                       undefined -> level simply registers the synchronised
//                                    input (DEBOUNCE_CYC ignored)
// ---------------------------------------------------------------------------

// One pushbutton channel: 2-flop synchroniser, optional debounce, strobes.
module tmnt_pb_lane #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int CNT_W        = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic press,
  output logic pb_rel
);
  logic [1:0] sync_pipe;
  logic       sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], pin};
  end

  assign sync = sync_pipe[1];

`ifdef TMNT_DEBOUNCE_EN
  // Counts consecutive cycles where sync disagrees with level. It is cleared
  // on agreement and on acceptance, so it never passes DEBOUNCE_CYC-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      pb_rel <= 1'b0;
    end else begin
      press  <= 1'b0;
      pb_rel <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // DEBOUNCE_CYC-th differing cycle: accept, strobe alongside new level
        level  <= ~level;
        press  <= ~level;
        pb_rel <= level;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  localparam int unused_cfg = DEBOUNCE_CYC + CNT_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      press  <= 1'b0;
      pb_rel <= 1'b0;
    end else begin
      level  <= sync;
      press  <= sync & ~level;
      pb_rel <= ~sync & level;
    end
  end
`endif
endmodule

module tmnt_gpio_frontend #(
  parameter int NUM_PB       = 16,
  parameter int GPIO_W       = 34,
  parameter int SIGOUT_PIN   = 33,
  parameter int DEBOUNCE_CYC = 1000
) (
  input logic                 clk,
  input logic                 nrst,
  tmnt_gpio_frontend_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  // ---------------- reset combine / release chain ----------------
  logic       rst_req_n;
  logic [1:0] rst_pipe;
  logic       core_nrst;

  assign rst_req_n = nrst & bus.cs;

  always_ff @(posedge clk or negedge rst_req_n) begin
    if (!rst_req_n) rst_pipe <= '0;
    else            rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign core_nrst     = rst_pipe[1];
  assign bus.core_nrst = core_nrst;

  // ---------------- pushbutton lanes ----------------
  logic [NUM_PB-1:0] pin;
  logic [NUM_PB-1:0] lvl;
  logic [NUM_PB-1:0] prs;
  logic [NUM_PB-1:0] rls;

  assign pin = bus.gpio_in[NUM_PB-1:0];

  tmnt_pb_lane #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_lane [NUM_PB-1:0] (
    .clk    (clk),
    .rst_n  (core_nrst),
    .pin    (pin),
    .level  (lvl),
    .press  (prs),
    .pb_rel (rls)
  );

  assign bus.pb_level   = lvl;
  assign bus.pb_press   = prs;
  assign bus.pb_release = rls;

  // Pads above the button range are not read by this block.
  logic unused_pins;
  assign unused_pins = ^bus.gpio_in[GPIO_W-1:NUM_PB];

  // ---------------- audio output path ----------------
  logic sig_q;

  always_ff @(posedge clk or negedge core_nrst) begin
    if (!core_nrst) sig_q <= 1'b0;
    else            sig_q <= bus.sigout;
  end

  // Only the sigout pad is ever driven; its enable follows core reset so
  // the pin tri-states the instant cs or nrst drops.
  always_comb begin
    bus.gpio_out             = '0;
    bus.gpio_out[SIGOUT_PIN] = sig_q;
  end

  always_comb begin
    bus.gpio_oe             = '0;
    bus.gpio_oe[SIGOUT_PIN] = core_nrst;
  end
endmodule

// File: tb/tb_tmnt_gpio_frontend.sv
module tb_tmnt_gpio_frontend;
  localparam int NUM_PB     = 16;
  localparam int GPIO_W     = 34;
  localparam int SIGOUT_PIN = 33;
  localparam int DBC        = 4;
`ifdef TMNT_DEBOUNCE_EN
  localparam int D_EFF = DBC;
`else
  localparam int D_EFF = 1;
`endif

  typedef struct packed {
    logic              core;
    logic [GPIO_W-1:0] out;
    logic [GPIO_W-1:0] oe;
    logic [NUM_PB-1:0] lvl;
    logic [NUM_PB-1:0] prs;
    logic [NUM_PB-1:0] rls;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;

  tmnt_gpio_frontend_if #(.NUM_PB(NUM_PB), .GPIO_W(GPIO_W)) bus ();

  tmnt_gpio_frontend #(
    .NUM_PB(NUM_PB), .GPIO_W(GPIO_W), .SIGOUT_PIN(SIGOUT_PIN), .DEBOUNCE_CYC(DBC)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t expq[$];

  // Reference model state: edges seen with reset request high, the pin
  // history since reset, the sync samples seen by the debouncer.
  int                rcnt = 0;
  logic [NUM_PB-1:0] hist[$];
  logic [NUM_PB-1:0] sq[$];
  logic [NUM_PB-1:0] m_lvl = '0;
  logic              m_sig = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected outputs after the coming clk edge, from the inputs now applied.
  task automatic model_edge();
    exp_t              e;
    logic [NUM_PB-1:0] sv, nl, same, w;
    bit                func;
    e = '0;
    if (!(nrst && bus.cs)) begin
      rcnt = 0;
      hist.delete();
      sq.delete();
      m_lvl = '0;
      m_sig = 1'b0;
    end else begin
      func = (rcnt >= 2);
      if (rcnt < 2) rcnt++;
      if (func) begin
        // sync seen at this edge = pin value two functional edges ago
        hist.push_back(bus.gpio_in[NUM_PB-1:0]);
        if (hist.size() > 3) void'(hist.pop_front());
        sv = (hist.size() == 3) ? hist[0] : '0;
        sq.push_back(sv);
        if (sq.size() > D_EFF) void'(sq.pop_front());
        // accept a level once the last D_EFF samples all agree on it
        same = '1;
        for (int k = 0; k < D_EFF; k++) begin
          w = (k < sq.size()) ? sq[k] : '0;
          same &= ~(w ^ sv);
        end
        nl    = (same & sv) | (~same & m_lvl);
        e.prs = nl & ~m_lvl;
        e.rls = ~nl & m_lvl;
        m_lvl = nl;
        m_sig = bus.sigout;
      end
      e.core = (rcnt >= 2);
    end
    e.lvl = m_lvl;
    e.out = GPIO_W'(m_sig) << SIGOUT_PIN;
    e.oe  = GPIO_W'(e.core) << SIGOUT_PIN;
    expq.push_back(e);
  endtask

  task automatic apply(input logic [NUM_PB-1:0] pb);
    logic [63:0] r;
    r = {$urandom, $urandom};
    bus.gpio_in = {r[GPIO_W-1:NUM_PB], pb};
    bus.sigout  = r[0];
  endtask

  task automatic drive(input logic n, input logic c, input logic [NUM_PB-1:0] pb);
    @(negedge clk);
    nrst   = n;
    bus.cs = c;
    apply(pb);
    model_edge();
  endtask

  task automatic hold(input logic [NUM_PB-1:0] pb, input int cyc);
    for (int k = 0; k < cyc; k++) drive(1'b1, 1'b1, pb);
  endtask

  // Drop cs between edges and confirm the reset takes effect without clk.
  task automatic drop_cs(input logic [NUM_PB-1:0] pb);
    @(negedge clk);
    #2;
    bus.cs = 1'b0;
    #1;
    chk("cs_async_core_nrst", 64'(bus.core_nrst), 64'd0);
    chk("cs_async_gpio_oe", 64'(bus.gpio_oe), 64'd0);
    chk("cs_async_pb_level", 64'(bus.pb_level), 64'd0);
    apply(pb);
    model_edge();
  endtask

  // Monitor: compares DUT outputs after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("core_nrst", 64'(bus.core_nrst), 64'(e.core));
        chk("gpio_out", 64'(bus.gpio_out), 64'(e.out));
        chk("gpio_oe", 64'(bus.gpio_oe), 64'(e.oe));
        chk("pb_level", 64'(bus.pb_level), 64'(e.lvl));
        chk("pb_press", 64'(bus.pb_press), 64'(e.prs));
        chk("pb_release", 64'(bus.pb_release), 64'(e.rls));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_PB-1:0] pb;
    nrst        = 1'b1;
    bus.cs      = 1'b1;
    bus.gpio_in = '0;
    bus.sigout  = 1'b0;
    #2 nrst = 1'b0;

    // reset hold, then release
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, '0);
    hold('0, 4);

    // clean press / release on channel 3
    hold(16'h0008, 10);
    hold(16'h0000, 10);

    // glitch of 3 cycles, then a 4-cycle pulse on channel 5
    hold(16'h0020, 3);
    hold(16'h0000, 8);
    hold(16'h0020, 4);
    hold(16'h0000, 10);

    // single-cycle glitch on channel 0
    hold(16'h0001, 1);
    hold(16'h0000, 8);

    // many channels at once
    hold(16'hA5A5, 10);
    hold(16'h0000, 10);

    // cs drop mid-cycle with buttons held, then re-release
    hold(16'hFFFF, 10);
    drop_cs(16'hFFFF);
    drive(1'b1, 1'b0, 16'hFFFF);
    hold(16'hFFFF, 10);

    // randomized: sparse toggles, occasional resets
    pb = '0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) pb ^= NUM_PB'($urandom & $urandom & $urandom);
      case ($urandom_range(0, 149))
        0:       drop_cs(pb);
        1:       drive(1'b0, 1'b1, pb);
        default: drive(1'b1, 1'b1, pb);
      endcase
    end
    hold('0, 12);

    @(posedge clk);
    #2;
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tmnt_gpio_frontend.md
# tmnt_gpio_frontend

Parametrised I/O front end between the breakout-board GPIO bank and the synthesiser core. Combines chip select with the board reset into a synchronised core reset, and synchronises and debounces a configurable number of pushbutton channels. Produces per-channel level, press and release strobes, and drives the core's audio output onto a selectable GPIO pin with a proper output enable. Sits directly under the chip wrapper, replacing its direct pin-to-core wiring.

## Interface
- `NUM_PB`, 16: pushbutton channels, mapped to `gpio_in[NUM_PB-1:0]`; 1..GPIO_W-1.
- `GPIO_W`, 34: GPIO bank width.
- `SIGOUT_PIN`, 33: GPIO index driven by `sigout`; must be ≥ NUM_PB and < GPIO_W.
- `DEBOUNCE_CYC`, 1000: consecutive stable cycles required to accept a new level; ≥ 1.
- `CNT_W`, $clog2(DEBOUNCE_CYC+1): debounce counter width (derived, not overridden).

- `clk`  in  1  single system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `cs`  in  1  chip select; 1 = block selected; 0 holds the block and core in reset.
- `gpio_in`  in  GPIO_W  pad input values.
- `gpio_out`  out  GPIO_W  pad output values.
- `gpio_oe`  out  GPIO_W  pad output enables, 1 = drive.
- `sigout`  in  1  audio output from the core.
- `core_nrst`  out  1  reset to the core, active-low, async assert / sync release.
- `pb_level`  out  NUM_PB  debounced button levels.
- `pb_press`  out  NUM_PB  one-cycle strobe on each 0→1 transition of `pb_level`.
- `pb_release`  out  NUM_PB  one-cycle strobe on each 1→0 transition of `pb_level`.

## Operation
- Reset combine: `rst_req_n = nrst & cs`.
  - A low on `rst_req_n` asynchronously clears a 2-flop release chain and drives `core_nrst` low.
  - `core_nrst` rises on the 2nd rising `clk` edge with `rst_req_n` high.
  - All internal flops use `core_nrst` as their asynchronous reset.
- Input sync: each `gpio_in[i]`, i < NUM_PB, passes through a 2-flop synchroniser that resets to 0. The output is `sync[i]`.
- Debounce, per channel, independent:
  - If `sync[i] == pb_level[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYC-1 and `sync[i]` still differs, `pb_level[i]` toggles and the counter clears. The new level is accepted on the DEBOUNCE_CYC-th consecutive differing cycle.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes `pb_level[i]`.
- Strobes: `pb_press[i]` and `pb_release[i]` are registered and high for exactly the one cycle in which `pb_level[i]` first shows its new value. They are never both high on the same channel.
- Output path:
  - `gpio_out[SIGOUT_PIN]` is `sigout`, registered by one flop.
  - `gpio_oe[SIGOUT_PIN] = core_nrst`.
  - All other `gpio_out` and `gpio_oe` bits are constant 0, so button pins stay inputs.
- Reset values: `core_nrst` 0; `pb_level`, `pb_press`, `pb_release` all 0; `gpio_out` all 0; `gpio_oe` all 0.
- Reset mid-debounce (`nrst` or `cs` low): counters, levels and strobes clear asynchronously, and `gpio_oe` drops in the same instant. A press that was in progress is discarded.
- Simultaneous events: any number of channels may toggle in the same cycle, and each channel is unaffected by the others.

## Timing
- Reset release: `core_nrst` goes high 2 edges after `rst_req_n` goes high. Assertion is combinational/asynchronous.
- Button latency: an input step held stable from before edge 0 reaches `sync` after edge 2. `pb_level` and the strobe update after edge 2+DEBOUNCE_CYC.
- With DEBOUNCE_CYC = 1, `pb_level` lags `sync` by one cycle.
- `sigout` to pad: 1 cycle.
- The counter never exceeds DEBOUNCE_CYC-1, so there is no wrap-around.

## Configuration
- Macro `TMNT_DEBOUNCE_EN`.
  - Defined: the debounce counters are built as described above.
  - Undefined: no counters are built. `pb_level[i]` registers `sync[i]` every cycle, for a latency of 3 edges. Strobes follow the same edge rule, and DEBOUNCE_CYC is ignored.

## Test plan
- Reset release: hold `nrst`=0 and `cs`=1, then release `nrst`. `core_nrst` is 0 after the 1st edge and 1 after the 2nd. `gpio_oe` = 1<<33 from then on.
- CS gating: with the block running, drive `cs`=0 mid-cycle. `core_nrst`, `gpio_oe` and `pb_level` go to 0 immediately without waiting for `clk`. Return `cs`=1 and the 2-edge release repeats.
- Clean press (DEBOUNCE_CYC=4): step `gpio_in[3]` 0→1. `pb_level[3]` rises after edge 6, with `pb_press[3]`=1 for exactly one cycle. Step back to 0 and `pb_release[3]` pulses after a further 6 edges.
- Glitch reject (DEBOUNCE_CYC=4): pulse `gpio_in[5]` high for 3 cycles, then low. `pb_level[5]` stays 0 and no strobe occurs. A 4-cycle-stable pulse is accepted.
- Multi-channel: toggle `gpio_in[15:0]` = 16'hA5A5 in one cycle. All eight channels set in `pb_level` and `pb_press` rise in the same cycle. `gpio_out[15:0]` and `gpio_oe[15:0]` remain 0.
- Macro undefined: step `gpio_in[0]` 0→1. `pb_level[0]` is 1 after edge 3, and a 1-cycle glitch passes through as a one-cycle `pb_press` followed by a `pb_release`.
